// File: rtl/mem_ops_pkg.sv
// Shared load/store encodings and FSM states for the data memory and the CPU MEM stage.
package mem_ops_pkg;

  // Enable bit positions inside the READ / WRITE request buses
  localparam int READ_EN  = 3;
  localparam int WRITE_EN = 2;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store width codes (low two bits of the store funct3)
  localparam logic [1:0] F3_SB = 2'b00;
  localparam logic [1:0] F3_SH = 2'b01;
  localparam logic [1:0] F3_SW = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  // Latched request operation
  typedef struct packed {
    logic       rd;
    logic [2:0] rd_f3;
    logic       wr;
    logic [1:0] wr_f;
  } mem_op_t;

endpackage

// File: rtl/data_memory_if.sv
// CPU data-side load/store bus.
interface data_memory_if;
  logic [3:0]  DATA_MEM_READ;
  logic [2:0]  DATA_MEM_WRITE;
  logic [31:0] DATA_MEM_ADDR;
  logic [31:0] DATA_MEM_WRITE_DATA;
  logic [31:0] DATA_MEM_READ_DATA;
  logic        DATA_MEM_BUSYWAIT;

  modport master (
    output DATA_MEM_READ, DATA_MEM_WRITE, DATA_MEM_ADDR, DATA_MEM_WRITE_DATA,
    input  DATA_MEM_READ_DATA, DATA_MEM_BUSYWAIT
  );

  modport slave (
    input  DATA_MEM_READ, DATA_MEM_WRITE, DATA_MEM_ADDR, DATA_MEM_WRITE_DATA,
    output DATA_MEM_READ_DATA, DATA_MEM_BUSYWAIT
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store mask/data replication and load extraction with extension.
module mem_lane_align
  import mem_ops_pkg::*;
(
  input  mem_op_t     i_op,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rword[{i_lane, 3'b000} +: 8];
  assign w_half = i_rword[{i_lane[1], 4'b0000} +: 16];

  // Store side: replicate the source so every enabled lane sees the right bits
  always_comb begin
    o_wmask = 4'b0000;
    o_wdata = i_wdata;
    if (i_op.wr) begin
      case (i_op.wr_f)
        F3_SB: begin
          o_wmask = 4'b0001 << i_lane;
          o_wdata = {4{i_wdata[7:0]}};
        end
        F3_SH: begin
          o_wmask = i_lane[1] ? 4'b1100 : 4'b0011;
          o_wdata = {2{i_wdata[15:0]}};
        end
        F3_SW:   o_wmask = 4'b1111;
        default: o_wmask = 4'b0000;
      endcase
    end
  end

  // Load side: a concurrent write or an unknown funct3 yields zero
  always_comb begin
    o_rdata = 32'h0;
    if (i_op.rd && !i_op.wr) begin
      case (i_op.rd_f3)
        F3_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
        F3_LH:   o_rdata = {{16{w_half[15]}}, w_half};
        F3_LW:   o_rdata = i_rword;
        F3_LBU:  o_rdata = {24'h0, w_byte};
        F3_LHU:  o_rdata = {16'h0, w_half};
        default: o_rdata = 32'h0;
      endcase
    end
  end
endmodule

// File: rtl/data_memory.sv
// Fixed-latency word memory behind the CPU MEM-stage load/store port.
module data_memory
  import mem_ops_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
)(
  input  logic          CLK,
  input  logic          RESET,
  data_memory_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  mem_state_e    r_state, w_next;
  logic [CW-1:0] r_cnt;
  mem_op_t       r_op;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_lane;
  logic [31:0]   r_wdata;
  logic [31:0]   r_read_data;
  logic [31:0]   r_mem [DEPTH];

  mem_op_t     w_op_in;
  logic        w_req, w_fire, w_load_upd;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata_sh, w_rdata;
  logic        w_unused_addr;

  assign w_op_in = '{rd:    bus.DATA_MEM_READ[READ_EN],
                     rd_f3: bus.DATA_MEM_READ[2:0],
                     wr:    bus.DATA_MEM_WRITE[WRITE_EN],
                     wr_f:  bus.DATA_MEM_WRITE[1:0]};
  assign w_req   = w_op_in.rd | w_op_in.wr;
  assign w_fire  = (r_state == ST_ACCESS) && (r_cnt == '0);
  // Unknown store width still overwrites READ_DATA with zero, like an unknown load
  assign w_load_upd = r_op.rd | (r_op.wr & (r_op.wr_f == 2'b11));
  // Address bits above the word index wrap and are intentionally dropped
  assign w_unused_addr = ^bus.DATA_MEM_ADDR[31:AW+2];

  mem_lane_align u_align (
    .i_op    (r_op),
    .i_lane  (r_lane),
    .i_wdata (r_wdata),
    .i_rword (r_mem[r_idx]),
    .o_wmask (w_wmask),
    .o_wdata (w_wdata_sh),
    .o_rdata (w_rdata)
  );

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_req) w_next = ST_ACCESS;
      ST_ACCESS: if (r_cnt == '0) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Stall is combinational so the CPU holds in the request cycle itself
  always_comb begin
    bus.DATA_MEM_BUSYWAIT = !RESET &&
      (((r_state == ST_IDLE) && w_req) || (r_state == ST_ACCESS));
  end

  // Request latches, latency counter and load result register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt       <= '0;
      r_op        <= '0;
      r_idx       <= '0;
      r_lane      <= '0;
      r_wdata     <= '0;
      r_read_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_req) begin
          r_op    <= w_op_in;
          r_idx   <= bus.DATA_MEM_ADDR[AW+1:2];
          r_lane  <= bus.DATA_MEM_ADDR[1:0];
          r_wdata <= bus.DATA_MEM_WRITE_DATA;
          r_cnt   <= CW'(LATENCY - 1);
        end
        ST_ACCESS: begin
          if (r_cnt != '0)    r_cnt       <= r_cnt - 1'b1;
          else if (w_load_upd) r_read_data <= w_rdata;
        end
        default: ;
      endcase
    end
  end

  // Array commit on the ACCESS-to-DONE edge; a reset on that edge aborts it
  always_ff @(posedge CLK) begin
    if (!RESET && w_fire) begin
      for (int i = 0; i < 4; i++)
        if (w_wmask[i]) r_mem[r_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
    end
  end

  assign bus.DATA_MEM_READ_DATA = r_read_data;
endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus a random load/store run.
module tb_data_memory;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 4;
  localparam int NWORDS  = 16;

  localparam logic [3:0] LB  = 4'b1000, LH  = 4'b1001, LW  = 4'b1010;
  localparam logic [3:0] LBU = 4'b1100, LHU = 4'b1101, LUND = 4'b1011;
  localparam logic [2:0] SB  = 3'b100,  SH  = 3'b101,  SW  = 3'b110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] model [NWORDS];

  data_memory_if bus();

  data_memory #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] ref_load(input logic [3:0] rd, input logic [31:0] w,
                                           input logic [1:0] ln);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * ln));
    h = 16'(w >> (16 * ln[1]));
    case (rd)
      LB:      return {{24{b[7]}}, b};
      LH:      return {{16{h[15]}}, h};
      LW:      return w;
      LBU:     return {24'h0, b};
      LHU:     return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(input logic [3:0] rd, input logic [2:0] wr,
                       input logic [31:0] a, input logic [31:0] d);
    bus.DATA_MEM_READ       = rd;
    bus.DATA_MEM_WRITE      = wr;
    bus.DATA_MEM_ADDR       = a;
    bus.DATA_MEM_WRITE_DATA = d;
  endtask

  // Counts consecutive busy cycles from now; returns settled in the DONE cycle
  task automatic run_access(output int n);
    n = 0;
    while (bus.DATA_MEM_BUSYWAIT === 1'b1 && n < 64) begin
      n++;
      @(posedge clk); #1;
    end
    if (n >= 64) begin
      errors++;
      $display("FAIL busy_timeout: busywait still high after %0d cycles", n);
    end
  endtask

  task automatic retire();
    drive(4'h0, 3'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic op(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] a,
                    input logic [31:0] d, output int n, output logic [31:0] r);
    drive(rd, wr, a, d);
    #1;
    run_access(n);
    r = bus.DATA_MEM_READ_DATA;
    retire();
  endtask

  task automatic test_reset();
    drive(LW, 3'h0, 32'h10, 32'h0);
    #12;
    checks++;
    if (bus.DATA_MEM_BUSYWAIT !== 1'b0) begin errors++;
      $display("FAIL reset_busy: got %b want 0", bus.DATA_MEM_BUSYWAIT); end
    checks++;
    if (bus.DATA_MEM_READ_DATA !== 32'h0) begin errors++;
      $display("FAIL reset_rdata: got %h want 00000000", bus.DATA_MEM_READ_DATA); end
    drive(4'h0, 3'h0, 32'h0, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.DATA_MEM_BUSYWAIT !== 1'b0) begin errors++;
      $display("FAIL idle_busy: got %b want 0", bus.DATA_MEM_BUSYWAIT); end
  endtask

  task automatic test_basic();
    int n; logic [31:0] r;
    op(4'h0, SW, 32'h10, 32'hDEADBEEF, n, r);
    checks++;
    if (n !== LATENCY + 1) begin errors++;
      $display("FAIL sw_busy_len: got %0d want %0d", n, LATENCY + 1); end
    op(LW, 3'h0, 32'h10, 32'h0, n, r);
    checks++;
    if (n !== LATENCY + 1) begin errors++;
      $display("FAIL lw_busy_len: got %0d want %0d", n, LATENCY + 1); end
    checks++;
    if (r !== 32'hDEADBEEF) begin errors++;
      $display("FAIL lw_basic: got %h want deadbeef", r); end
  endtask

  task automatic test_subword_loads();
    int n; logic [31:0] r;
    logic [3:0]  rds [4] = '{LB, LBU, LH, LHU};
    logic [31:0] as  [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    for (int i = 0; i < 4; i++) begin
      op(rds[i], 3'h0, as[i], 32'h0, n, r);
      checks++;
      if (r !== exp[i]) begin errors++;
        $display("FAIL subword_load[%0d]: got %h want %h", i, r, exp[i]); end
    end
  endtask

  task automatic test_sb_sh();
    int n; logic [31:0] r;
    op(4'h0, SB, 32'h11, 32'hFFFFFF55, n, r);
    op(LW, 3'h0, 32'h10, 32'h0, n, r);
    checks++;
    if (r !== 32'hDEAD55EF) begin errors++;
      $display("FAIL sb_merge: got %h want dead55ef", r); end
    op(4'h0, SH, 32'h12, 32'hFFFF1234, n, r);
    op(LW, 3'h0, 32'h10, 32'h0, n, r);
    checks++;
    if (r !== 32'h123455EF) begin errors++;
      $display("FAIL sh_merge: got %h want 123455ef", r); end
  endtask

  task automatic test_wrap_b2b();
    int n; logic [31:0] r;
    drive(4'h0, SW, 32'(4 * DEPTH + 32'h10), 32'hCAFEF00D);
    #1;
    run_access(n);
    // next request presented during DONE, CPU-style
    drive(LW, 3'h0, 32'h10, 32'h0);
    @(posedge clk); #1;
    checks++;
    if (bus.DATA_MEM_BUSYWAIT !== 1'b1) begin errors++;
      $display("FAIL b2b_busy: got %b want 1", bus.DATA_MEM_BUSYWAIT); end
    run_access(n);
    r = bus.DATA_MEM_READ_DATA;
    retire();
    checks++;
    if (n !== LATENCY + 1) begin errors++;
      $display("FAIL b2b_busy_len: got %0d want %0d", n, LATENCY + 1); end
    checks++;
    if (r !== 32'hCAFEF00D) begin errors++;
      $display("FAIL wrap_lw: got %h want cafef00d", r); end
  endtask

  task automatic test_reset_mid_access();
    int n; logic [31:0] r;
    op(4'h0, SW, 32'h20, 32'h11111111, n, r);
    op(LW, 3'h0, 32'h20, 32'h0, n, r);
    checks++;
    if (r !== 32'h11111111) begin errors++;
      $display("FAIL pre_reset_lw: got %h want 11111111", r); end
    drive(4'h0, SW, 32'h20, 32'hAAAAAAAA);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.DATA_MEM_BUSYWAIT !== 1'b0) begin errors++;
      $display("FAIL midreset_busy: got %b want 0", bus.DATA_MEM_BUSYWAIT); end
    checks++;
    if (bus.DATA_MEM_READ_DATA !== 32'h0) begin errors++;
      $display("FAIL midreset_rdata: got %h want 00000000", bus.DATA_MEM_READ_DATA); end
    drive(4'h0, 3'h0, 32'h0, 32'h0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    op(LW, 3'h0, 32'h20, 32'h0, n, r);
    checks++;
    if (r !== 32'h11111111) begin errors++;
      $display("FAIL aborted_store: got %h want 11111111", r); end
  endtask

  task automatic test_rw_both_and_undef();
    int n; logic [31:0] r;
    op(LW, SW, 32'h30, 32'h00000077, n, r);
    checks++;
    if (r !== 32'h0) begin errors++;
      $display("FAIL rw_both_rdata: got %h want 00000000", r); end
    op(LW, 3'h0, 32'h30, 32'h0, n, r);
    checks++;
    if (r !== 32'h00000077) begin errors++;
      $display("FAIL rw_both_word: got %h want 00000077", r); end
    op(LUND, 3'h0, 32'h30, 32'h0, n, r);
    checks++;
    if (n !== LATENCY + 1) begin errors++;
      $display("FAIL undef_busy_len: got %0d want %0d", n, LATENCY + 1); end
    checks++;
    if (r !== 32'h0) begin errors++;
      $display("FAIL undef_rdata: got %h want 00000000", r); end
  endtask

  task automatic test_random();
    int n; logic [31:0] r, a, d, expv;
    int idx, k;
    logic [3:0] rds [5] = '{LB, LH, LW, LBU, LHU};
    logic [2:0] wrs [3] = '{SB, SH, SW};
    for (int i = 0; i < NWORDS; i++) begin
      model[i] = $urandom;
      op(4'h0, SW, 32'(i * 4), model[i], n, r);
    end
    for (int t = 0; t < 150; t++) begin
      idx = $urandom_range(0, NWORDS - 1);
      a   = ($urandom & ~32'(((DEPTH - 1) << 2))) | 32'(idx << 2);
      d   = $urandom;
      k   = $urandom_range(0, 7);
      if (k < 3) begin
        op(4'h0, wrs[k], a, d, n, r);
        case (k)
          0:       model[idx][8 * a[1:0] +: 8]  = d[7:0];
          1:       model[idx][16 * a[1] +: 16]  = d[15:0];
          default: model[idx]                   = d;
        endcase
      end else begin
        op(rds[k - 3], 3'h0, a, 32'h0, n, r);
        expv = ref_load(rds[k - 3], model[idx], a[1:0]);
        checks++;
        if (r !== expv) begin errors++;
          $display("FAIL rand_load[%0d] addr %h: got %h want %h", t, a, r, expv); end
      end
      checks++;
      if (n !== LATENCY + 1) begin errors++;
        $display("FAIL rand_busy_len[%0d]: got %0d want %0d", t, n, LATENCY + 1); end
    end
  endtask

  initial begin
    drive(4'h0, 3'h0, 32'h0, 32'h0);
    test_reset();
    test_basic();
    test_subword_loads();
    test_sb_sh();
    test_wrap_b2b();
    test_reset_mid_access();
    test_rw_both_and_undef();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data memory that serves the CPU's MEM-stage load/store port. It accepts the CPU's encoded read/write requests, holds BUSYWAIT high for a fixed, parameterised access latency, and commits stores with byte/halfword lane masking. It returns loads with RISC-V sign or zero extension. It sits directly downstream of `cpu` on the data side and replaces the tied-low DATA_MEM_BUSYWAIT used in standalone CPU simulation.

## Interface
- DEPTH, 256: number of 32-bit words; the word index is ADDR[log2(DEPTH)+1:2], and higher address bits are ignored, so addresses wrap modulo DEPTH.
- LATENCY, 4: ACCESS-state cycles per request; minimum 1.

- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- DATA_MEM_READ  in  4  [3] read enable; [2:0] funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- DATA_MEM_WRITE  in  3  [2] write enable; [1:0]: 00 SB, 01 SH, 10 SW.
- DATA_MEM_ADDR  in  32  byte address.
- DATA_MEM_WRITE_DATA  in  32  store data; the low bytes are used for SB and SH.
- DATA_MEM_READ_DATA  out  32  extended load result.
- DATA_MEM_BUSYWAIT  out  1  stall request to the CPU.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE with REQ = READ[3] | WRITE[2]:
  - latch op, address and write data;
  - set counter to LATENCY-1;
  - go to ACCESS.
- IDLE with REQ low: stay in IDLE.
- ACCESS, counter != 0: decrement the counter.
- ACCESS, counter == 0: perform the access and go to DONE.
  - Store: write the enabled byte lanes into the array.
  - Load: register the extended result into READ_DATA.
- DONE: return to IDLE unconditionally. The request visible during DONE is the one being retired, not a new request.
- Byte lane is ADDR[1:0].
  - SB writes lane ADDR[1:0].
  - SH writes lanes {ADDR[1],0} and {ADDR[1],1}; ADDR[0] is ignored.
  - SW writes all four lanes; ADDR[1:0] is ignored.
- Loads select the same lanes as the matching store width.
  - LB and LH sign-extend from bit 7 and bit 15.
  - LBU and LHU zero-extend.
- Undefined read funct3 (011, 110, 111) or write code 11: no array update, READ_DATA = 0, full latency still applied.
- Simultaneous read and write enable: the write is performed and READ_DATA = 0.
- The memory array is not cleared by RESET and powers up X.

## Timing
- DATA_MEM_BUSYWAIT = (IDLE & REQ) | ACCESS. It is combinational from the inputs so the CPU stalls in the request cycle itself.
- BUSYWAIT is high for exactly LATENCY+1 consecutive cycles per request, counting the request cycle. It is low in DONE, and the CPU advances on the edge that ends DONE.
- READ_DATA is valid from entry to DONE and holds until the next load completes.
- A store is committed on the ACCESS-to-DONE edge, never earlier.
- Inputs are sampled only in IDLE. Changes during ACCESS or DONE are ignored.
- Back-to-back requests: a request present in the first IDLE cycle after DONE starts a new access with no extra bubble.
- RESET at any time, including mid-ACCESS:
  - state becomes IDLE, the counter becomes 0 and READ_DATA becomes 0;
  - a pending store is aborted and the array is unmodified;
  - BUSYWAIT is 0 while RESET is high.

## Structure
- Shared package `mem_ops_pkg` holds:
  - the funct3 encodings (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - the enable-bit positions (READ_EN = 3, WRITE_EN = 2);
  - the FSM state encoding.
  The CPU's MEM stage uses the same package.
- One sub-module, `mem_lane_align`, is purely combinational:
  - from op and ADDR[1:0] it produces the 4-bit byte-write mask and the shifted write data;
  - from the raw word it produces the extended load data.
- The top level holds the FSM, the latency counter, the request latches and the array.

## Test plan
- Reset, then SW 0xDEADBEEF to addr 0x10, with LATENCY=4 → BUSYWAIT high for exactly 5 cycles. A later LW from 0x10 returns 0xDEADBEEF.
- Byte and halfword loads from the word at 0x10:
  - LB 0x13 returns 0xFFFFFFDE;
  - LBU 0x13 returns 0x000000DE;
  - LH 0x12 returns 0xFFFFDEAD;
  - LHU 0x10 returns 0x0000BEEF.
- SB 0x55 to 0x11 over 0xDEADBEEF, then LW 0x10 → 0xDEAD55EF. SH 0x1234 to 0x12, then LW 0x10 → 0x123455EF.
- Wrap-around and back-to-back:
  - SW to addr 4*DEPTH+0x10, then LW 0x10 → same data;
  - issue the LW in the cycle right after DONE → BUSYWAIT rises that same cycle with no idle gap.
- RESET asserted on the 2nd ACCESS cycle of SW 0xAAAAAAAA to 0x20 that had 0x11111111 → BUSYWAIT drops immediately, READ_DATA = 0, and a later LW 0x20 returns 0x11111111.
- Read and write enables both set (SW 0x77 to 0x30 with LW) → word 0x30 = 0x00000077 and READ_DATA = 0. An undefined read funct3 011 → READ_DATA = 0 after the full latency.
